// File: rtl/stats_pkg.sv
// Shared definitions for the statistics increment stream: default field
// widths, scanner state encoding and the saturating-add helper.
package stats_pkg;

  localparam int STAT_INC_WIDTH_DEF = 16;
  localparam int STAT_ID_WIDTH_DEF  = 8;

  // Widest accumulator the helper supports.
  localparam int SAT_MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Unsigned add of a and b, both interpreted as w-bit values. If the sum
  // carries out of w bits, return w ones instead.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input logic [6:0]           w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] limit;
    logic [SAT_MAX_W:0] ones;
    sum      = {1'b0, a} + {1'b0, b};
    limit    = '0;
    limit[w] = 1'b1;
    ones     = limit - {{SAT_MAX_W{1'b0}}, 1'b1};
    if (sum >= limit) begin
      sat_add = ones[SAT_MAX_W-1:0];
    end else begin
      sat_add = sum[SAT_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/stats_acc_sat.sv
// One saturating event accumulator. A clear reloads it with only this
// cycle's increment, so a count arriving in the drain cycle is kept.
module stats_acc_sat
  import stats_pkg::*;
#(
  parameter int W = STAT_INC_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inc,
  input  logic         valid,
  input  logic         clear,
  output logic [W-1:0] acc
);

  logic [W-1:0] sum;

  assign sum = W'(sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(inc), 7'(W)));

  // Accumulate, or restart from this cycle's increment when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= valid ? inc : '0;
    end else if (valid) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/stats_collect.sv
// Collects per-channel event increments into saturating accumulators and
// drains the nonzero ones as (tid, tdata) words on an AXI-stream master.
module stats_collect
  import stats_pkg::*;
#(
  parameter int STAT_COUNT     = 8,
  parameter int STAT_INC_WIDTH = STAT_INC_WIDTH_DEF,
  parameter int STAT_ID_WIDTH  = STAT_ID_WIDTH_DEF,
  parameter int STAT_ID_BASE   = 0,
  parameter int UPDATE_PERIOD  = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [STAT_COUNT*STAT_INC_WIDTH-1:0] stat_inc,
  input  logic [STAT_COUNT-1:0]                stat_valid,
  input  logic                                 update,
  output logic [STAT_INC_WIDTH-1:0]            m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0]             m_axis_stat_tid,
  output logic                                 m_axis_stat_tvalid,
  input  logic                                 m_axis_stat_tready
);

  localparam int CH_W      = (STAT_COUNT > 1) ? $clog2(STAT_COUNT) : 1;
  localparam int TMR_W     = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int TMR_LOAD  = (UPDATE_PERIOD > 0) ? UPDATE_PERIOD - 1 : 0;
  localparam bit TIMER_EN  = (UPDATE_PERIOD > 0);
  localparam logic [CH_W-1:0]          LAST_CH = CH_W'(STAT_COUNT - 1);
  localparam logic [STAT_ID_WIDTH-1:0] ID_BASE = STAT_ID_WIDTH'(STAT_ID_BASE);

  logic [STAT_INC_WIDTH-1:0] acc [STAT_COUNT];
  logic [STAT_COUNT-1:0]     clear;

  scan_state_t               state, state_next;
  logic [CH_W-1:0]           ch, ch_next;
  logic                      pending, pending_next;
  logic [TMR_W-1:0]          timer;
  logic                      any_msb;
  logic                      trigger;
  logic                      slot_free;
  logic                      emit;
  logic [STAT_INC_WIDTH-1:0] acc_cur;

  for (genvar i = 0; i < STAT_COUNT; i++) begin : g_acc
    stats_acc_sat #(
      .W(STAT_INC_WIDTH)
    ) u_acc (
      .clk  (clk),
      .rst  (rst),
      .inc  (stat_inc[i*STAT_INC_WIDTH +: STAT_INC_WIDTH]),
      .valid(stat_valid[i]),
      .clear(clear[i]),
      .acc  (acc[i])
    );
  end

  // Any accumulator past half scale asks for an early drain.
  always_comb begin
    any_msb = 1'b0;
    for (int i = 0; i < STAT_COUNT; i++) begin
      any_msb = any_msb | acc[i][STAT_INC_WIDTH-1];
    end
  end

  assign trigger   = update || any_msb || (TIMER_EN && (timer == '0));
  assign slot_free = !m_axis_stat_tvalid || m_axis_stat_tready;
  assign acc_cur   = acc[ch];

  // Free-running flush timer, reloaded on expiry.
  always_ff @(posedge clk) begin
    if (rst || timer == '0) begin
      timer <= TMR_W'(TMR_LOAD);
    end else begin
      timer <= timer - 1'b1;
    end
  end

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      ch      <= ch_next;
      pending <= pending_next;
    end
  end

  // Scanner next state: walk channels one per free output slot.
  always_comb begin
    state_next   = state;
    ch_next      = ch;
    pending_next = pending;
    emit         = 1'b0;
    clear        = '0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_next   = SCAN;
          ch_next      = '0;
          pending_next = 1'b0;
        end
      end
      SCAN: begin
        if (trigger) begin
          pending_next = 1'b1;
        end
        if (slot_free) begin
          if (acc_cur != '0) begin
            emit      = 1'b1;
            clear[ch] = 1'b1;
          end
          if (ch == LAST_CH) begin
            ch_next = '0;
            if (pending_next) begin
              pending_next = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            ch_next = ch + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output word register: load on emit, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_stat_tvalid <= 1'b0;
      m_axis_stat_tdata  <= '0;
      m_axis_stat_tid    <= '0;
    end else if (emit) begin
      m_axis_stat_tvalid <= 1'b1;
      m_axis_stat_tdata  <= acc_cur;
      m_axis_stat_tid    <= ID_BASE + STAT_ID_WIDTH'(ch);
    end else if (m_axis_stat_tready) begin
      m_axis_stat_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stats_collect.sv
// Directed bench for stats_collect: table-driven drains plus hand-written
// sequences for latency, collision, backpressure, saturation, timer, reset.
module tb_stats_collect;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int IDW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] stat_inc;
  logic [N-1:0]   stat_valid;
  logic           update;
  logic           tready;
  logic [W-1:0]   tdata, tdata2;
  logic [IDW-1:0] tid, tid2;
  logic           tvalid, tvalid2;

  int errors = 0;
  int checks = 0;

  logic [23:0] q[$];
  logic [23:0] q2[$];

  always #5 clk = ~clk;

  stats_collect #(
    .STAT_COUNT(N), .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(IDW),
    .STAT_ID_BASE(0), .UPDATE_PERIOD(0)
  ) dut (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid),
    .update(update), .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid),
    .m_axis_stat_tvalid(tvalid), .m_axis_stat_tready(tready)
  );

  stats_collect #(
    .STAT_COUNT(N), .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(IDW),
    .STAT_ID_BASE(0), .UPDATE_PERIOD(16)
  ) dut_tmr (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid),
    .update(update), .m_axis_stat_tdata(tdata2), .m_axis_stat_tid(tid2),
    .m_axis_stat_tvalid(tvalid2), .m_axis_stat_tready(1'b1)
  );

  // Record accepted words; inputs change just after posedge, so the
  // handshake is stable here.
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) q.push_back({tid, tdata});
      if (tvalid2) q2.push_back({tid2, tdata2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input int idx, input logic [7:0] etid,
                          input logic [15:0] edata);
    logic [23:0] w;
    w = (idx < q.size()) ? q[idx] : 24'hFFFFFF;
    chk({name, "_tid"}, 32'(w[23:16]), 32'(etid));
    chk({name, "_tdata"}, 32'(w[15:0]), 32'(edata));
  endtask

  task automatic pulse(input int ch, input logic [15:0] v);
    stat_inc = '0;
    stat_valid = '0;
    stat_inc[ch*W +: W] = v;
    stat_valid[ch] = 1'b1;
    tick();
    stat_inc = '0;
    stat_valid = '0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  typedef struct {
    int          ch_a;
    logic [15:0] inc_a;
    int          ch_b;
    logic [15:0] inc_b;
    int          n;
    logic [7:0]  tid0;
    logic [15:0] d0;
    logic [7:0]  tid1;
    logic [15:0] d1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic held;
    vecs[0] = '{2, 16'd5,      2, 16'd7,      1, 8'd2, 16'd12,     8'd0, 16'd0};
    vecs[1] = '{0, 16'd1,      7, 16'd9,      2, 8'd0, 16'd1,      8'd7, 16'd9};
    vecs[2] = '{3, 16'h7FFF,   3, 16'h0001,   1, 8'd3, 16'h8000,   8'd0, 16'd0};
    vecs[3] = '{6, 16'hFFF0,   6, 16'h0100,   1, 8'd6, 16'hFFFF,   8'd0, 16'd0};
    vecs[4] = '{5, 16'd0,      1, 16'd0,      0, 8'd0, 16'd0,      8'd0, 16'd0};

    rst = 1'b1;
    stat_inc = '0;
    stat_valid = '0;
    update = 1'b0;
    tready = 1'b1;
    ticks(3);
    rst = 1'b0;

    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_tid", 32'(tid), 32'd0);

    // Timer instance flushes by itself; the period-0 instance does not.
    q.delete();
    q2.delete();
    pulse(5, 16'd1);
    for (int i = 0; i < 40; i++) begin
      if (q2.size() != 0) break;
      tick();
    end
    chk("timer_word_seen", 32'(q2.size() != 0), 32'd1);
    chk("timer_tid", 32'((q2.size() != 0) ? q2[0][23:16] : 8'hFF), 32'd5);
    chk("timer_tdata", 32'((q2.size() != 0) ? q2[0][15:0] : 16'hFFFF), 32'd1);
    chk("notimer_no_word", 32'(q.size()), 32'd0);
    do_update();
    ticks(20);
    chk("notimer_upd_count", 32'(q.size()), 32'd1);
    chk_word("notimer_upd", 0, 8'd5, 16'd1);

    // Table-driven drains.
    for (int v = 0; v < 5; v++) begin
      q.delete();
      pulse(vecs[v].ch_a, vecs[v].inc_a);
      pulse(vecs[v].ch_b, vecs[v].inc_b);
      do_update();
      ticks(30);
      chk($sformatf("vec%0d_count", v), 32'(q.size()), 32'(vecs[v].n));
      if (vecs[v].n >= 1) chk_word($sformatf("vec%0d_w0", v), 0, vecs[v].tid0, vecs[v].d0);
      if (vecs[v].n >= 2) chk_word($sformatf("vec%0d_w1", v), 1, vecs[v].tid1, vecs[v].d1);
      chk($sformatf("vec%0d_idle", v), 32'(tvalid), 32'd0);
    end

    // Trigger to first tvalid is two cycles.
    q.delete();
    pulse(0, 16'd9);
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("lat_before", 32'(tvalid), 32'd0);
    tick();
    chk("lat_tvalid", 32'(tvalid), 32'd1);
    chk("lat_tid", 32'(tid), 32'd0);
    chk("lat_tdata", 32'(tdata), 32'd9);
    ticks(15);

    // Increment landing in the same cycle its channel is drained.
    q.delete();
    pulse(0, 16'd3);
    update = 1'b1;
    tick();
    update = 1'b0;
    stat_inc[0 +: W] = 16'd4;
    stat_valid[0] = 1'b1;
    tick();
    stat_inc = '0;
    stat_valid = '0;
    chk("coll_tdata", 32'(tdata), 32'd3);
    ticks(15);
    do_update();
    ticks(20);
    chk("coll_count", 32'(q.size()), 32'd2);
    chk_word("coll_w0", 0, 8'd0, 16'd3);
    chk_word("coll_w1", 1, 8'd0, 16'd4);

    // Backpressure holds the word, then drains back-to-back.
    tready = 1'b0;
    q.delete();
    stat_inc = '0;
    stat_inc[0*W +: W] = 16'd1;
    stat_inc[1*W +: W] = 16'd2;
    stat_inc[2*W +: W] = 16'd3;
    stat_inc[3*W +: W] = 16'd4;
    stat_valid = 8'h0F;
    tick();
    stat_inc = '0;
    stat_valid = '0;
    do_update();
    tick();
    held = 1'b1;
    repeat (10) begin
      tick();
      if (!(tvalid && tid == 8'd0 && tdata == 16'd1)) held = 1'b0;
    end
    chk("bp_held", 32'(held), 32'd1);
    chk("bp_tdata", 32'(tdata), 32'd1);
    chk("bp_none_taken", 32'(q.size()), 32'd0);
    tready = 1'b1;
    ticks(4);
    chk("bp_b2b_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_word($sformatf("bp_w%0d", i), i, 8'(i), 16'(i + 1));
    ticks(10);
    chk("bp_final_count", 32'(q.size()), 32'd4);

    // Saturation and half-full self-trigger, no update pulse.
    q.delete();
    pulse(1, 16'hFFFF);
    pulse(1, 16'hFFFF);
    ticks(30);
    chk("sat_count", 32'(q.size()), 32'd1);
    chk_word("sat_w0", 0, 8'd1, 16'hFFFF);
    q.delete();
    pulse(4, 16'h8000);
    ticks(30);
    chk("half_count", 32'(q.size()), 32'd1);
    chk_word("half_w0", 0, 8'd4, 16'h8000);

    // Reset in the middle of a scan discards everything.
    tready = 1'b0;
    q.delete();
    stat_inc = '0;
    stat_inc[1*W +: W] = 16'd1;
    stat_inc[2*W +: W] = 16'd2;
    stat_inc[4*W +: W] = 16'd4;
    stat_valid = 8'h16;
    tick();
    stat_inc = '0;
    stat_valid = '0;
    do_update();
    ticks(2);
    chk("rstscan_pre_tvalid", 32'(tvalid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstscan_tvalid", 32'(tvalid), 32'd0);
    chk("rstscan_tdata", 32'(tdata), 32'd0);
    rst = 1'b0;
    tready = 1'b1;
    ticks(2);
    do_update();
    ticks(20);
    chk("rstscan_no_words", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
